// File: rtl/jesd204_rx_header_lock_64b.sv
// 64B/66B sync-header block lock: hunts for a stable 01/10 header, asks the
// gearbox to bitslip until it finds one, then forwards qualified payload while locked.
`timescale 1ns/1ps

// state  | meaning
// HUNT   | counting consecutive valid headers towards lock
// SLIP   | bitslip issued, gearbox settling, headers ignored
// LOCKED | block lock held, invalid headers monitored per window
module jesd204_rx_header_lock_64b #(
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_ERRORS = 16,
  parameter int SLIP_WAIT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_header,
  input  logic [63:0] in_data,
  output logic        bitslip,
  output logic        locked,
  output logic        out_valid,
  output logic [1:0]  out_header,
  output logic [63:0] out_data,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  localparam int HW = $clog2(LOCK_COUNT) + 1;
  localparam int WW = $clog2(UNLOCK_WINDOW) + 1;
  localparam int EW = $clog2(UNLOCK_ERRORS) + 1;
  localparam int SW = $clog2(SLIP_WAIT) + 1;

  localparam logic [HW-1:0] HUNT_LAST = HW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(UNLOCK_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(UNLOCK_ERRORS - 1);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SLIP   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hunt_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_win;
  logic [SW-1:0] slip_tmr;

  logic hdr_ok;
  logic hunt_fail;
  logic hunt_done;
  logic lk_beat;
  logic lk_bad;
  logic lose;
  logic win_end;

  assign hdr_ok    = in_header[1] ^ in_header[0];
  assign hunt_fail = (state == HUNT) && in_valid && !hdr_ok;
  assign hunt_done = (state == HUNT) && in_valid && hdr_ok && (hunt_cnt == HUNT_LAST);
  assign lk_beat   = (state == LOCKED) && in_valid;
  assign lk_bad    = lk_beat && !hdr_ok;
  // the beat that completes the window is counted before the window resets
  assign lose      = lk_bad && (err_win == ERR_LAST);
  assign win_end   = lk_beat && (win_cnt == WIN_LAST);

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      hunt_cnt <= '0;
      win_cnt  <= '0;
      err_win  <= '0;
      slip_tmr <= '0;
      bitslip  <= 1'b0;
    end else begin
      bitslip <= hunt_fail | lose;
      case (state)
        HUNT: begin
          win_cnt <= '0;
          err_win <= '0;
          if (hunt_fail) begin
            state    <= SLIP;
            hunt_cnt <= '0;
            slip_tmr <= SLIP_LAST;
          end else if (hunt_done) begin
            state    <= LOCKED;
            hunt_cnt <= '0;
          end else if (in_valid) begin
            hunt_cnt <= hunt_cnt + 1'b1;
          end
        end
        SLIP: begin
          if (slip_tmr == '0) begin
            state    <= HUNT;
            hunt_cnt <= '0;
          end else begin
            slip_tmr <= slip_tmr - 1'b1;
          end
        end
        LOCKED: begin
          if (lose) begin
            state    <= SLIP;
            slip_tmr <= SLIP_LAST;
            win_cnt  <= '0;
            err_win  <= '0;
          end else if (win_end) begin
            win_cnt <= '0;
            err_win <= '0;
          end else if (lk_beat) begin
            win_cnt <= win_cnt + 1'b1;
            if (lk_bad) err_win <= err_win + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // the beat that drops lock is not flagged, so out_valid falls with locked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_header <= '0;
      out_data   <= '0;
    end else begin
      out_valid <= lk_beat && !lose;
      if (in_valid) begin
        out_header <= in_header;
        out_data   <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (lk_bad && (err_count != 8'hff)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
